crossbar_nport: RTL and testbench

Parametrised N-port registered crossbar for the multi-lane router, successor to the fixed 2-port combinational crossbar. It moves beats from any input port to any subset of output ports (unicast or multicast, selected by a one-hot destination mask) with valid/ready handshakes on both sides. A shared round-robin pointer arbitrates between inputs, and a grant stays locked to one input for a whole packet. It sits between the per-lane Aurora RX buffers and the TX lane framers.

---
 rtl/crossbar_nport.sv | 139 +++++++++++++
 tb/tb_crossbar_nport.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_nport.sv
// N-input / N-output registered crossbar with one-hot/multi-hot destination masks,
// a shared round-robin pointer and per-output packet locking.
module crossbar_nport #(
   parameter  int DATA_WIDTH = 256,
   parameter  int NUM_PORTS  = 4,
   localparam int SRC_W      = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            in_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_PORTS-1:0]            in_last,
   input  logic [NUM_PORTS*NUM_PORTS-1:0]  in_dest,
   output logic [NUM_PORTS-1:0]            in_ready,
   output logic [NUM_PORTS-1:0]            out_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_PORTS-1:0]            out_last,
   output logic [NUM_PORTS*SRC_W-1:0]      out_src,
   input  logic [NUM_PORTS-1:0]            out_ready
);

   logic [NUM_PORTS-1:0]            out_valid_q, out_valid_d;
   logic [NUM_PORTS-1:0]            out_last_q,  out_last_d;
   logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [NUM_PORTS*SRC_W-1:0]      out_src_q,   out_src_d;
   logic [NUM_PORTS-1:0]            lock_q,      lock_d;
   logic [NUM_PORTS*SRC_W-1:0]      owner_q,     owner_d;
   logic [SRC_W-1:0]                ptr_q,       ptr_d;

   logic [NUM_PORTS-1:0]            free;
   logic [NUM_PORTS*SRC_W-1:0]      grant;
   logic [NUM_PORTS-1:0]            load;

   // (base + off) mod NUM_PORTS for 0 <= off < NUM_PORTS; also correct for non-power-of-2 port counts
   function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      return SRC_W'(sum);
   endfunction

   assign free = ~out_valid_q | out_ready;

   // A locked output only listens to its owner; otherwise the requester closest to
   // ptr wins. Scanning downward lets the last (closest) match overwrite the others.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      grant = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (lock_q[j]) begin
            grant[j*SRC_W +: SRC_W] = owner_q[j*SRC_W +: SRC_W];
         end else begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
               if (in_valid[wrap_add(ptr_q, k)] &&
                   in_dest[int'(wrap_add(ptr_q, k))*NUM_PORTS + j]) begin
                  grant[j*SRC_W +: SRC_W] = wrap_add(ptr_q, k);
               end
            end
         end
      end
   end

   // All-or-nothing: every destination leg must be granted to i and free.
   always_comb begin
      in_ready = in_valid;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (in_dest[i*NUM_PORTS + j] &&
                !(grant[j*SRC_W +: SRC_W] == SRC_W'(i) && free[j])) begin
               in_ready[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin : next_state
      int src;
      src         = 0;
      load        = '0;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      lock_d      = lock_q;
      owner_d     = owner_q;
      for (int j = 0; j < NUM_PORTS; j++) begin
         src     = int'(grant[j*SRC_W +: SRC_W]);
         load[j] = in_ready[src] && in_dest[src*NUM_PORTS + j];
         if (load[j]) begin
            out_valid_d[j]                        = 1'b1;
            out_data_d[j*DATA_WIDTH +: DATA_WIDTH] = in_data[src*DATA_WIDTH +: DATA_WIDTH];
            out_last_d[j]                         = in_last[src];
            out_src_d[j*SRC_W +: SRC_W]           = grant[j*SRC_W +: SRC_W];
            lock_d[j]                             = !in_last[src];
            if (!in_last[src]) owner_d[j*SRC_W +: SRC_W] = grant[j*SRC_W +: SRC_W];
         end else if (out_ready[j]) begin
            out_valid_d[j] = 1'b0;
         end
      end
   end

   // Pointer moves past the first packet-ending input at or after ptr.
   always_comb begin
      ptr_d = ptr_q;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (in_ready[wrap_add(ptr_q, k)] && in_last[wrap_add(ptr_q, k)]) begin
            ptr_d = wrap_add(wrap_add(ptr_q, k), 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data registers are reset too, so out_data reads as zero straight after reset.
         out_valid_q <= '0;
         out_last_q  <= '0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         lock_q      <= '0;
         owner_q     <= '0;
         ptr_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         lock_q      <= lock_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_crossbar_nport.sv
// Bench for crossbar_nport: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the arbitration and output registers.
module tb_crossbar_nport;
   localparam int DW = 256;
   localparam int N  = 4;
   localparam int SW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    in_valid, in_last, in_ready, out_valid, out_last, out_ready;
   logic [N*DW-1:0] in_data, out_data;
   logic [N*N-1:0]  in_dest;
   logic [N*SW-1:0] out_src;

   crossbar_nport #(.DATA_WIDTH(DW), .NUM_PORTS(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_dest(in_dest),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N-1:0]  m_ov, m_ol, m_lock, m_fire, smp_ready;
   logic [DW-1:0] m_od [N];
   int            m_os [N];
   int            m_owner [N];
   int            m_ptr;

   task automatic model_reset();
      m_ov = '0; m_ol = '0; m_lock = '0; m_fire = '0; m_ptr = 0;
      for (int j = 0; j < N; j++) begin
         m_od[j] = '0; m_os[j] = 0; m_owner[j] = 0;
      end
   endtask

   task automatic model_comb();
      int g [N];
      for (int j = 0; j < N; j++) begin
         g[j] = -1;
         if (m_lock[j]) g[j] = m_owner[j];
         else
            for (int k = 0; k < N; k++) begin
               int p;
               p = (m_ptr + k) % N;
               if (g[j] < 0 && in_valid[p] && in_dest[p*N + j]) g[j] = p;
            end
      end
      for (int i = 0; i < N; i++) begin
         m_fire[i] = in_valid[i];
         for (int j = 0; j < N; j++)
            if (in_dest[i*N + j] && !(g[j] == i && (!m_ov[j] || out_ready[j]))) m_fire[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int first_last;
      first_last = -1;
      for (int j = 0; j < N; j++) begin
         int src;
         src = -1;
         for (int i = 0; i < N; i++) if (m_fire[i] && in_dest[i*N + j]) src = i;
         if (src >= 0) begin
            m_ov[j] = 1'b1;
            m_od[j] = in_data[src*DW +: DW];
            m_ol[j] = in_last[src];
            m_os[j] = src;
            if (in_last[src]) m_lock[j] = 1'b0;
            else begin
               m_lock[j]  = 1'b1;
               m_owner[j] = src;
            end
         end else if (out_ready[j]) m_ov[j] = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
         int p;
         p = (m_ptr + k) % N;
         if (first_last < 0 && m_fire[p] && in_last[p]) first_last = p;
      end
      if (first_last >= 0) m_ptr = (first_last + 1) % N;
   endtask

   task automatic check_outputs();
      check("out_valid", out_valid, m_ov);
      for (int j = 0; j < N; j++)
         if (m_ov[j]) begin
            check($sformatf("out_data[%0d]", j), out_data[j*DW +: DW], m_od[j]);
            check($sformatf("out_last[%0d]", j), out_last[j], m_ol[j]);
            check($sformatf("out_src[%0d]", j), out_src[j*SW +: SW], m_os[j]);
         end
   endtask

   task automatic check_reset_outputs();
      check("rst_out_valid", out_valid, '0);
      check("rst_out_last", out_last, '0);
      check("rst_out_src", out_src, '0);
      for (int j = 0; j < N; j++) check($sformatf("rst_out_data[%0d]", j), out_data[j*DW +: DW], '0);
   endtask

   // One clock: inputs already applied at posedge+1; returns at next posedge+1.
   task automatic cycle();
      #3;
      model_comb();
      smp_ready = in_ready;
      check("in_ready", in_ready, m_fire);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   // ---------------- senders ----------------
   logic [N-1:0]  s_dest [N];
   int            s_rem  [N];
   logic [DW-1:0] s_data [N];

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] v;
      for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [N-1:0] rand_dest();
      logic [N-1:0] d;
      int r;
      d = '0;
      r = $urandom_range(0, 15);
      if (r == 0) d = '0;
      else if (r < 4) d = N'($urandom_range(1, (1 << N) - 1));
      else d[$urandom_range(0, N-1)] = 1'b1;
      return d;
   endfunction

   task automatic set_in(input int i, input logic v, input logic [N-1:0] d, input logic l,
                         input logic [DW-1:0] dat);
      in_valid[i] = v; in_dest[i*N +: N] = d; in_last[i] = l; in_data[i*DW +: DW] = dat;
   endtask

   task automatic start_pkt(input int i, input logic [N-1:0] d, input int beats);
      s_dest[i] = d; s_rem[i] = beats;
   endtask

   task automatic drive(input bit rnd);
      for (int i = 0; i < N; i++)
         if (!in_valid[i]) begin
            if (rnd && s_rem[i] == 0 && $urandom_range(0, 2) == 0)
               start_pkt(i, rand_dest(), int'($urandom_range(1, 4)));
            if (s_rem[i] > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
               s_data[i] = rand_beat();
               set_in(i, 1'b1, s_dest[i], s_rem[i] == 1, s_data[i]);
            end
         end
      if (rnd) for (int j = 0; j < N; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
   endtask

   task automatic retire();
      for (int i = 0; i < N; i++)
         if (in_valid[i] && m_fire[i]) begin
            in_valid[i] = 1'b0;
            if (s_rem[i] > 0) s_rem[i]--;
         end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            got_src[$];
      int            exp_order [4];
      logic [DW-1:0] saved;
      exp_order = '{0, 0, 1, 1};

      in_valid = '0; in_last = '0; in_data = '0; in_dest = '0; out_ready = '0;
      for (int i = 0; i < N; i++) begin s_rem[i] = 0; s_dest[i] = '0; s_data[i] = '0; end
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Unicast: input 2, three beats to output 0
      out_ready = '1;
      start_pkt(2, 4'b0001, 3);
      for (int b = 0; b < 3; b++) begin
         drive(0); cycle(); retire();
         check("uni_valid", out_valid[0], 1'b1);
         check("uni_src", out_src[SW-1:0], 2);
         check("uni_last", out_last[0], b == 2);
      end

      // Pointer now 3: input 3 beats input 0 for output 1
      start_pkt(0, 4'b0010, 1);
      start_pkt(3, 4'b0010, 1);
      drive(0); cycle();
      check("ptr_arb", smp_ready, 4'b1000);
      retire();
      check("ptr_src", out_src[1*SW +: SW], 3);
      in_valid[0] = 1'b0; s_rem[0] = 0;

      // Contention: inputs 0 and 1, two beats each to output 3, pointer back at 0
      start_pkt(0, 4'b1000, 2);
      start_pkt(1, 4'b1000, 2);
      for (int c = 0; c < 12 && (s_rem[0] + s_rem[1]) > 0; c++) begin
         drive(0); cycle();
         if (c < 2) check("cont_block1", smp_ready[1], 1'b0);
         retire();
         if (out_valid[3]) got_src.push_back(int'(out_src[3*SW +: SW]));
      end
      check("cont_done", s_rem[0] + s_rem[1], 0);
      check("cont_count", got_src.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < got_src.size()) check($sformatf("cont_order[%0d]", k), got_src[k], exp_order[k]);

      // Multicast blocked by output 3 back-pressure, then released
      out_ready = 4'b0111;
      start_pkt(1, 4'b1010, 1);
      for (int c = 0; c < 2; c++) begin
         drive(0); cycle();
         check("mc_blocked", smp_ready[1], 1'b0);
         check("mc_idle1", out_valid[1], 1'b0);
         check("mc_hold3", out_valid[3], 1'b1);
         retire();
      end
      out_ready = '1;
      drive(0); cycle();
      check("mc_fire", smp_ready[1], 1'b1);
      check("mc_v1", out_valid[1], 1'b1);
      check("mc_v3", out_valid[3], 1'b1);
      check("mc_d1", out_data[1*DW +: DW], s_data[1]);
      check("mc_d3", out_data[3*DW +: DW], s_data[1]);
      retire();

      // Parallel unicast ring
      start_pkt(0, 4'b0010, 4);
      start_pkt(1, 4'b0100, 4);
      start_pkt(2, 4'b1000, 4);
      start_pkt(3, 4'b0001, 4);
      for (int c = 0; c < 4; c++) begin
         drive(0); cycle();
         check("par_ready", smp_ready, 4'hF);
         check("par_valid", out_valid, 4'hF);
         retire();
      end

      // Hold output 0 while dropping dest=0 beats from input 2
      out_ready = 4'b1110;
      saved = m_od[0];
      for (int c = 0; c < 3; c++) begin
         set_in(2, 1'b1, '0, 1'b1, rand_beat());
         cycle();
         check("drop_ready", smp_ready[2], 1'b1);
         check("hold_valid", out_valid[0], 1'b1);
         check("hold_data", out_data[0 +: DW], saved);
         retire();
      end
      out_ready = '1;
      drive(0); cycle(); retire();

      // Reset in the middle of a 4-beat packet from input 1
      start_pkt(1, 4'b0001, 4);
      drive(0); cycle(); retire();
      start_pkt(3, 4'b0001, 1);
      drive(0); cycle();
      check("rst_lock_block", smp_ready[3], 1'b0);
      check("rst_beat2_src", out_src[SW-1:0], 1);
      retire();
      drive(0);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs();
      model_reset();
      in_valid[1] = 1'b0; s_rem[1] = 0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      drive(0); cycle();
      check("rst_new_ready", smp_ready[3], 1'b1);
      check("rst_new_valid", out_valid[0], 1'b1);
      check("rst_new_src", out_src[SW-1:0], 3);
      retire();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         drive(1); cycle(); retire();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
